// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder: accepts words over valid/ready and shifts them out one bit per clock,
// back-to-back with no gap, holding IDLE_BIT on the line when nothing is loaded.
module seq_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     ser_ready,
    output logic                     ser_bit,
    output logic                     ser_valid,
    output logic                     word_done,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int unsigned         IdxW    = $clog2(WIDTH);
    localparam logic [IdxW-1:0]     LastIdx = IdxW'(WIDTH - 1);
    localparam logic [IdxW-1:0]     IdxOne  = IdxW'(1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             ser_bit_q, ser_bit_d;

    logic busy;
    logic last;
    logic accept;

    assign busy   = (state_q == StShift);
    assign last   = busy && (idx_q == LastIdx);
    // Gated by reset_n so the source sees in_ready=0 for the whole reset window.
    assign in_ready  = reset_n && (!busy || (ser_ready && last));
    assign accept    = in_valid && in_ready;
    assign word_done = last && ser_ready;

    assign ser_valid = busy;
    assign ser_bit   = ser_bit_q;
    assign bit_idx   = idx_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        if (accept) begin
            state_d = StShift;
            shift_d = in_data;
            idx_d   = '0;
        end else if (busy && ser_ready) begin
            if (last) begin
                state_d = StIdle;
                shift_d = '0;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IdxOne;
                if (LSB_FIRST) begin
                    shift_d = shift_q >> 1;
                end else begin
                    shift_d = shift_q << 1;
                end
            end
        end

        // The line bit is registered: precompute what the next shift position will present.
        if (state_d == StShift) begin
            ser_bit_d = LSB_FIRST ? shift_d[0] : shift_d[WIDTH-1];
        end else begin
            ser_bit_d = IDLE_BIT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            idx_q     <= '0;
            ser_bit_q <= IDLE_BIT;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            ser_bit_q <= ser_bit_d;
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: directed scenarios plus random traffic, compared
// against a bit-queue reference model.
module tb_seq_bit_serializer;

    localparam int unsigned W  = 8;
    localparam int unsigned W2 = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         ser_ready = 1'b1;
    logic         ser_bit;
    logic         ser_valid;
    logic         word_done;
    logic [2:0]   bit_idx;

    logic [W2-1:0] b_in_data = '0;
    logic          b_in_valid = 1'b0;
    logic          b_in_ready;
    logic          b_ser_bit;
    logic          b_ser_valid;
    logic          b_word_done;
    logic [1:0]    b_bit_idx;

    int total = 0;
    int bad   = 0;

    logic mq[$];     // bits still to appear on the line, front = current bit
    logic acc;

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_ready(ser_ready), .ser_bit(ser_bit), .ser_valid(ser_valid),
        .word_done(word_done), .bit_idx(bit_idx)
    );

    seq_bit_serializer #(.WIDTH(W2), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .ser_ready(1'b1), .ser_bit(b_ser_bit),
        .ser_valid(b_ser_valid), .word_done(b_word_done), .bit_idx(b_bit_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, check against the model, then advance it.
    task automatic step(input logic v, input logic [W-1:0] d, input logic sr);
        int sz;
        logic exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        ser_ready = sr;
        #1;
        sz      = mq.size();
        exp_rdy = (sz == 0) || (sz == 1 && sr);
        check("ser_valid", 32'(ser_valid), 32'(sz > 0));
        check("ser_bit", 32'(ser_bit), 32'((sz > 0) ? mq[0] : 1'b0));
        check("bit_idx", 32'(bit_idx), (sz > 0) ? 32'(W - sz) : 32'd0);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("word_done", 32'(word_done), 32'(sz == 1 && sr));
        acc = v && exp_rdy;
        @(posedge clk);
        if (sr && sz > 0) void'(mq.pop_front());
        if (acc) for (int i = W - 1; i >= 0; i--) mq.push_back(d[i]);
    endtask

    task automatic lsb_word(input logic [W2-1:0] w);
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = w;
        #1 check("lsb_in_ready", 32'(b_in_ready), 32'd1);
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_data  = ~w;
        for (int i = 0; i < int'(W2); i++) begin
            #1;
            check("lsb_valid", 32'(b_ser_valid), 32'd1);
            check("lsb_bit", 32'(b_ser_bit), 32'(w[i]));
            check("lsb_idx", 32'(b_bit_idx), 32'(i));
            check("lsb_done", 32'(b_word_done), 32'(i == int'(W2) - 1));
            @(negedge clk);
        end
        #1 check("lsb_idle", 32'(b_ser_valid), 32'd0);
    endtask

    initial begin
        int w;
        logic [W-1:0] words[2];
        // Reset state
        #12;
        check("rst_valid", 32'(ser_valid), 32'd0);
        check("rst_bit", 32'(ser_bit), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_idx", 32'(bit_idx), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic MSB-first 0xB0, then idle cycles
        step(1'b1, 8'hB0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 8'($urandom), 1'b1);

        // Back-to-back 0xA5 then 0x3C with in_valid held high
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        w = 0;
        while (w < 2) begin
            step(1'b1, words[w], 1'b1);
            if (acc) w++;
        end
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

        // Backpressure: 0xF0 with ser_ready low for 3 cycles at bit_idx 2
        step(1'b1, 8'hF0, 1'b1);
        while (W - mq.size() != 2) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);

        // Input stability after accepting 0x81
        step(1'b1, 8'h81, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 8'($urandom), 1'b1);

        // Reset mid-word at bit_idx 3 of 0xFF, asserted between edges
        step(1'b1, 8'hFF, 1'b1);
        while (W - mq.size() != 3) step(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_valid", 32'(ser_valid), 32'd0);
        check("midrst_bit", 32'(ser_bit), 32'd0);
        check("midrst_idx", 32'(bit_idx), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        mq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h0F, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

        // LSB-first, 4-bit instance
        lsb_word(4'hD);
        for (int i = 0; i < 4; i++) lsb_word(4'($urandom));

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
